// File: rtl/and5_vec_checker.sv
// and5_vec_checker: steps vec through 0..LAST, holds each vector SETTLE cycles, then checks dut_out against AND(vec).
// Comparator present only when AND5_SELF_CHECK_EN is defined; otherwise err_cnt_o stays 0 and pass_o follows done_o.
module and5_vec_checker #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned LAST   = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       dut_out_i,
    output logic [4:0] vec_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [5:0] err_cnt_o,
    output logic       pass_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [4:0] LAST_V      = 5'(LAST);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    // With SETTLE=0 every vector goes straight to its compare cycle.
    localparam state_t     FIRST_ST    = (SETTLE == 0) ? S_CHECK : S_SETTLE;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] vec_q, vec_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [5:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       mismatch;

`ifdef AND5_SELF_CHECK_EN
    assign mismatch = (state_q == S_CHECK) && (dut_out_i != (&vec_q));
`else
    logic unused_dut_out;
    assign unused_dut_out = dut_out_i;
    assign mismatch       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = FIRST_ST;
                    cnt_d   = 4'd0;
                    vec_d   = 5'd0;
                    valid_d = 1'b1;
                    err_d   = 6'd0;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d = 4'd0;
                if (mismatch && (err_q != 6'd63)) begin
                    err_d = err_q + 6'd1;
                end
                if (vec_q == LAST_V) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                end else begin
                    state_d = FIRST_ST;
                    vec_d   = vec_q + 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status flags are decoded from the next state so they are registered alongside it.
        busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == 6'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            vec_q   <= 5'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 6'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_o     = vec_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_cnt_o = err_q;
    assign pass_o    = pass_q;

endmodule

// File: tb/tb_and5_vec_checker.sv
// Bench for and5_vec_checker: one instance with SETTLE=1 and a fault-injectable gate, one with SETTLE=0.
// Outputs are compared every cycle against a run-time model, plus literal expectations for each scenario.
module tb_and5_vec_checker;

`ifdef AND5_SELF_CHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start1, start0;
    int         fault1;
    logic       dut_out1, dut_out0;
    logic [4:0] vec1, vec0;
    logic       valid1, busy1, done1, pass1;
    logic       valid0, busy0, done0, pass0;
    logic [5:0] err1, err0;

    // Gate under test: 0 = correct AND, 1 = stuck at 0, 2 = stuck at 1.
    assign dut_out1 = (fault1 == 0) ? (&vec1) : (fault1 == 1) ? 1'b0 : 1'b1;
    assign dut_out0 = &vec0;

    and5_vec_checker #(.SETTLE(1), .LAST(31)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .dut_out_i(dut_out1),
        .vec_o(vec1), .valid_o(valid1), .busy_o(busy1), .done_o(done1),
        .err_cnt_o(err1), .pass_o(pass1)
    );

    and5_vec_checker #(.SETTLE(0), .LAST(31)) u_dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .dut_out_i(dut_out0),
        .vec_o(vec0), .valid_o(valid0), .busy_o(busy0), .done_o(done0),
        .err_cnt_o(err0), .pass_o(pass0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a run is a count t of cycles since the start edge; vector k is judged at t=(k+1)*(S+1).
    typedef struct {
        bit run;
        bit dn;
        int t;
        int err;
        int vec;
    } mdl_t;

    function automatic bit bad(input int k, input int flt);
        bit g;
        bit f;
        g = (k == 31);
        f = (flt == 0) ? g : (flt == 1) ? 1'b0 : 1'b1;
        return f != g;
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic r, input logic st, input int s, input int flt);
        mdl_t n;
        n = m;
        if (r) begin
            n.run = 0; n.dn = 0; n.t = 0; n.err = 0; n.vec = 0;
        end else if (!m.run && st) begin
            n.run = 1; n.dn = 0; n.t = 0; n.err = 0; n.vec = 0;
        end else if (m.run) begin
            n.t = m.t + 1;
`ifdef AND5_SELF_CHECK_EN
            if ((n.t % (s + 1)) == 0) begin
                if (bad(n.t / (s + 1) - 1, flt) && n.err < 63) n.err = n.err + 1;
            end
`endif
            if (n.t == 32 * (s + 1)) begin
                n.run = 0; n.dn = 1; n.vec = 31;
            end else begin
                n.vec = n.t / (s + 1);
            end
        end
        return n;
    endfunction

    mdl_t m1, m0;
    bit   model_on = 1'b0;

    always @(posedge clk) begin
        m1 <= step(m1, rst, start1, 1, fault1);
        m0 <= step(m0, rst, start0, 0, 0);
        if (rst === 1'b1) model_on <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("vec1", 32'(vec1), m1.vec);
            chk("valid1", 32'(valid1), 32'(m1.run));
            chk("busy1", 32'(busy1), 32'(m1.run));
            chk("done1", 32'(done1), 32'(m1.dn));
            chk("err1", 32'(err1), m1.err);
            chk("pass1", 32'(pass1), 32'(m1.dn && m1.err == 0));
            chk("vec0", 32'(vec0), m0.vec);
            chk("valid0", 32'(valid0), 32'(m0.run));
            chk("busy0", 32'(busy0), 32'(m0.run));
            chk("done0", 32'(done0), 32'(m0.dn));
            chk("err0", 32'(err0), m0.err);
            chk("pass0", 32'(pass0), 32'(m0.dn && m0.err == 0));
        end
    end

    // Cycles from the start-sampling edge until done1 is seen; called just after that edge.
    task automatic count1(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (done1 === 1'b1) break;
        end
    endtask

    task automatic run1(output int n);
        @(posedge clk); #3 start1 = 1'b1;
        @(posedge clk); #3 start1 = 1'b0;
        count1(n);
    endtask

    int  n;
    bit  saw10;

    initial begin
        rst = 1'b1; start1 = 1'b0; start0 = 1'b0; fault1 = 0;
        @(posedge clk); @(posedge clk); #3;
        chk("reset_outs1", {vec1, valid1, busy1, done1, err1, pass1}, 32'd0);
        chk("reset_outs0", {vec0, valid0, busy0, done0, err0, pass0}, 32'd0);
        rst = 1'b0;

        // Correct gate.
        run1(n);
        chk("good_latency", n, 64);
        chk("good_err", 32'(err1), 0);
        chk("good_pass", 32'(pass1), 1);
        chk("good_vec_last", 32'(vec1), 31);
        chk("good_valid_off", 32'(valid1), 0);

        // Stuck at 0: only 5'b11111 mismatches.
        fault1 = 1;
        run1(n);
        chk("s0_latency", n, 64);
        chk("s0_err", 32'(err1), SC ? 1 : 0);
        chk("s0_pass", 32'(pass1), SC ? 0 : 1);

        // Stuck at 1: every vector except 5'b11111 mismatches; restart from DONE must clear err.
        fault1 = 2;
        run1(n);
        chk("s1_latency", n, 64);
        chk("s1_err", 32'(err1), SC ? 31 : 0);
        chk("s1_pass", 32'(pass1), SC ? 0 : 1);

        // Mid-run reset at vec=10, then start on the first cycle after reset.
        @(posedge clk); #3 start1 = 1'b1;
        @(posedge clk); #3 start1 = 1'b0;
        saw10 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #3;
            if (vec1 === 5'd10) begin saw10 = 1'b1; break; end
        end
        chk("saw_vec10", 32'(saw10), 1);
        rst = 1'b1;
        @(posedge clk); #3;
        rst = 1'b0;
        chk("midrst_outs", {vec1, valid1, busy1, done1, err1, pass1}, 32'd0);
        start1 = 1'b1;
        @(posedge clk); #3 start1 = 1'b0;
        chk("restart_vec0", 32'(vec1), 0);
        chk("restart_busy", 32'(busy1), 1);
        count1(n);
        chk("rerun_latency", n, 64);
        chk("rerun_err", 32'(err1), SC ? 31 : 0);

        // SETTLE=0 with start held high across the whole run.
        @(posedge clk); #3 start0 = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (done0 === 1'b1) break;
        end
        chk("s0set_latency", n, 32);
        chk("s0set_pass", 32'(pass0), 1);
        @(posedge clk); #1;
        chk("done_restart_done", 32'(done0), 0);
        chk("done_restart_busy", 32'(busy0), 1);
        chk("done_restart_vec", 32'(vec0), 0);
        chk("done_restart_err", 32'(err0), 0);
        #2 start0 = 1'b0;

        repeat (40) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
